// File: rtl/input_debounce_sync.sv
// rtl/input_debounce_sync.sv - per-channel 2-flop synchroniser and counter debouncer; DEBOUNCE_EDGE_EN builds rise/fall/changed pulse registers
module input_debounce_sync #(
  parameter int WIDTH           = 8,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  // Terminal count: a level differing from dout is accepted on the edge after cnt reaches this
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 1 ||
        longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_W) - longint'(1))) begin : g_bad_cfg
      $error("input_debounce_sync: DEBOUNCE_CYCLES must be in 1..2^CNT_W-1");
    end
  endgenerate

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] dout_next;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];

  // Next debounced level and counter per channel; a matching level always clears the counter
  always_comb begin
    dout_next = dout;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != dout[i]) begin
        if (cnt[i] == CNT_LAST) begin
          dout_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Synchroniser chain, debounced levels and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      dout  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      dout  <= dout_next;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  // Edge pulses registered alongside dout so they appear in the same cycle as the new level
  always_ff @(posedge clk) begin
    if (rst) begin
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      rise    <= dout_next & ~dout;
      fall    <= ~dout_next & dout;
      changed <= |(dout_next ^ dout);
    end
  end
`else
  assign rise    = '0;
  assign fall    = '0;
  assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_input_debounce_sync.sv
// tb/tb_input_debounce_sync.sv - scoreboard bench for input_debounce_sync with DEBOUNCE_CYCLES=4
module tb_input_debounce_sync;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout, rise, fall;
  logic       changed;

  input_debounce_sync #(
    .WIDTH(8),
    .CNT_W(16),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .dout(dout),
    .rise(rise),
    .fall(fall),
    .changed(changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    logic [7:0] dout;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       changed;
  } exp_t;

  exp_t exp_q[$];

  int   edge_n   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;
  logic [7:0] prev_dout = 8'h00;

`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGES = 1'b1;
`else
  localparam bit EDGES = 1'b0;
`endif

  always @(posedge clk) edge_n++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  // Expected dout change at edge_no; edge outputs are zero in the build without pulse registers
  task automatic expect_evt(input int edge_no, input logic [7:0] d,
                            input logic [7:0] r, input logic [7:0] f);
    exp_t e;
    e.edge_no = edge_no;
    e.dout    = d;
    e.rise    = EDGES ? r : 8'h00;
    e.fall    = EDGES ? f : 8'h00;
    e.changed = EDGES ? ((r | f) != 8'h00) : 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: a dout change is the DUT's output event; pop and compare, otherwise pulses must be quiet
  always @(negedge clk) begin
    if (mon_en) begin
      if (dout !== prev_dout) begin
        if (exp_q.size() == 0) begin
          check("unexpected_dout_change", {24'h0, dout}, {24'h0, prev_dout});
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("event_edge",    edge_n,            e.edge_no);
          check("event_dout",    {24'h0, dout},     {24'h0, e.dout});
          check("event_rise",    {24'h0, rise},     {24'h0, e.rise});
          check("event_fall",    {24'h0, fall},     {24'h0, e.fall});
          check("event_changed", {31'h0, changed},  {31'h0, e.changed});
        end
      end else begin
        check("quiet_pulses", {15'h0, changed, rise, fall}, 32'h0);
      end
      prev_dout = dout;
    end
  end

  int n;

  initial begin
    // Test 1: reset with all inputs high
    din = 8'hFF;
    rst = 1'b1;
    tick(1);
    mon_en = 1'b1;
    check("reset_dout", {24'h0, dout}, 32'h0);
    tick(1);
    check("reset_dout2", {24'h0, dout}, 32'h0);
    rst = 1'b0;
    tick(1);
    check("post_reset_dout", {24'h0, dout}, 32'h0);
    check("post_reset_changed", {31'h0, changed}, 32'h0);
    din = 8'h00;
    tick(8);

    // Test 2: single channel rise, then back low
    n = edge_n;
    din = 8'h01;
    expect_evt(n + D + 2, 8'h01, 8'h01, 8'h00);
    tick(10);
    n = edge_n;
    din = 8'h00;
    expect_evt(n + D + 2, 8'h00, 8'h00, 8'h01);
    tick(10);

    // Test 3: three-edge glitch on bit 3 is rejected
    din = 8'h08;
    tick(3);
    din = 8'h00;
    tick(10);
    check("glitch_dout", {24'h0, dout}, 32'h0);

    // Test 4: multi-channel rise and fall
    n = edge_n;
    din = 8'hA5;
    expect_evt(n + D + 2, 8'hA5, 8'hA5, 8'h00);
    tick(10);
    n = edge_n;
    din = 8'h00;
    expect_evt(n + D + 2, 8'h00, 8'h00, 8'hA5);
    tick(10);

    // Test 5: reset at the third edge discards the in-flight transition
    n = edge_n;
    din = 8'h01;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_reset_dout", {24'h0, dout}, 32'h0);
    expect_evt(n + 3 + D + 2, 8'h01, 8'h01, 8'h00);
    tick(12);
    check("final_dout", {24'h0, dout}, 32'h01);

    mon_en = 1'b0;
    check("events_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
